// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared definitions for the serial frame transmitter:
//   - state_t   : frame sequencer states (IDLE, START, DATA, PARITY, GAP)
//   - START_LEN : number of 1 bits that open every frame
//   - even_parity(): XOR reduction of a payload, zero-extended to 32 bits
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int START_LEN = 2;

  // Zero extension does not change the XOR, so one 32-bit helper serves
  // every legal payload width.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// frame_shift_reg
//   Payload holding register for the transmitter: parallel load, shift right
//   by one, least significant bit presented on lsb.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-low reset (clears the register)
//   load  in   capture d (takes priority over shift)
//   shift in   shift right by one, 0 enters at the top
//   d     in   [W-1:0] parallel payload
//   lsb   out  current bit 0 of the register
module frame_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         lsb
);

  logic [W-1:0] r_data;

  // Payload register: reset, load, shift or hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= {W{1'b0}};
    end else if (load) begin
      r_data <= d;
    end else if (shift) begin
      r_data <= {1'b0, r_data[W-1:1]};
    end else begin
      r_data <= r_data;
    end
  end

  assign lsb = r_data[0];

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Sends one frame per accepted payload on a single registered line:
//   two 1 start bits, DATA_W payload bits LSB first, one even-parity bit,
//   then IDLE_GAP guard bits of 0. Line idles at 0.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   tx_data  in   [DATA_W-1:0] payload, sampled only on the accept edge
//   tx_valid in   upstream offers tx_data
//   tx_ready out  block is idle and out of reset (combinational from state)
//   out      out  registered serial line
//   busy     out  high while a frame occupies the line
//   done     out  one-cycle pulse in the first idle cycle after a frame
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  // Counter must reach the longest counted state; with the default
  // parameters this is $clog2(DATA_W+1) bits.
  localparam int CNT_MAX = (DATA_W > IDLE_GAP) ? DATA_W : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_out;
  logic             r_busy;
  logic             r_done;
  logic             r_parity;
  logic             w_accept;
  logic             w_shift;
  logic             w_lsb;
  logic             w_out_next;

  assign tx_ready = (r_state == IDLE) && reset;
  assign w_accept = tx_valid && tx_ready;

  frame_shift_reg #(
    .W(DATA_W)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (w_accept),
    .shift(w_shift),
    .d    (tx_data),
    .lsb  (w_lsb)
  );

  // Next-state and bit-counter logic; the counter restarts on every state entry.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt + CNT_W'(1);
    case (r_state)
      IDLE: begin
        w_cnt_next = {CNT_W{1'b0}};
        if (w_accept) begin
          w_next = START;
        end else begin
          w_next = IDLE;
        end
      end
      START: begin
        if (r_cnt == CNT_W'(START_LEN - 1)) begin
          w_next     = DATA;
          w_cnt_next = {CNT_W{1'b0}};
        end else begin
          w_next = START;
        end
      end
      DATA: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_next     = PARITY;
          w_cnt_next = {CNT_W{1'b0}};
        end else begin
          w_next = DATA;
        end
      end
      PARITY: begin
        w_next     = GAP;
        w_cnt_next = {CNT_W{1'b0}};
      end
      GAP: begin
        if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
          w_next     = IDLE;
          w_cnt_next = {CNT_W{1'b0}};
        end else begin
          w_next = GAP;
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = {CNT_W{1'b0}};
      end
    endcase
  end

  // Line value for the coming cycle, chosen from the state being entered so
  // that out lines up with the registered state. Each DATA entry consumes
  // the current LSB and shifts the next payload bit into place.
  always_comb begin
    w_out_next = 1'b0;
    w_shift    = 1'b0;
    case (w_next)
      START: begin
        w_out_next = 1'b1;
      end
      DATA: begin
        w_out_next = w_lsb;
        w_shift    = 1'b1;
      end
      PARITY: begin
        w_out_next = r_parity;
      end
      default: begin
        w_out_next = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; parity is captured with the payload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_out   <= w_out_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (r_state == GAP) && (w_next == IDLE);
      if (w_accept) begin
        r_parity <= even_parity(32'(tx_data));
      end else begin
        r_parity <= r_parity;
      end
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 2..32.
REQ-002 Parameter IDLE_GAP, default 2, number of guard cycles of 0 after each frame; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 tx_data  input  DATA_W  parallel payload; sampled only on the accept edge.
REQ-006 tx_valid  input  1  upstream offers tx_data.
REQ-007 tx_ready  output  1  block can accept a payload this cycle.
REQ-008 out  output  1  registered serial line consumed by the team's serial-input FSMs (idle level 0).
REQ-009 busy  output  1  high while a frame is on the line.
REQ-010 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The frame SHALL be sent in this order, one bit per clk cycle:
- START: two 1 bits.
- DATA: DATA_W payload bits, LSB first.
- PARITY: one even-parity bit, equal to the XOR of all payload bits.
- GAP: IDLE_GAP bits of 0.
REQ-012 The state machine SHALL have five states: IDLE -> START -> DATA -> PARITY -> GAP -> IDLE, with no other transitions except reset.
REQ-013 tx_ready SHALL equal (state==IDLE) AND reset; it is combinational from registered state only and never depends on tx_valid.
REQ-014 Accept SHALL occur on an edge where tx_valid && tx_ready. On that edge:
- tx_data loads into the shift register.
- The state moves to START.
- out becomes 1 in the following cycle (latency 1 from accept to first line bit).
REQ-015 tx_valid and tx_data SHALL be ignored outside IDLE; changing tx_data mid-frame SHALL NOT alter out.
REQ-016 busy SHALL be high in every cycle where state is not IDLE, i.e. exactly 3+DATA_W+IDLE_GAP cycles per frame.
REQ-017 done SHALL pulse high for exactly one cycle: the first IDLE cycle after GAP, concurrent with tx_ready=1.
REQ-018 Back-to-back behaviour: with tx_valid held high, the next accept occurs in the done cycle, so the frame period is 4+DATA_W+IDLE_GAP cycles.
REQ-019 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL reset to 0 on entry to each counted state; it never wraps within a state.
REQ-020 out SHALL be 0 in IDLE and in GAP; no glitch or extra 1 bit is permitted between frames.

Reset
REQ-021 When reset==0 at a clk edge, the block SHALL set:
- state=IDLE
- out=0
- busy=0
- done=0
- shift register=0
- counter=0
REQ-022 tx_ready SHALL be 0 while reset==0 and SHALL become 1 in the first cycle after reset is sampled high.
REQ-023 Reset mid-frame SHALL abort the frame immediately with no done pulse; the partial frame is not resumed.

Structure
REQ-024 A shared package serial_frame_pkg SHALL hold:
- the state enum (IDLE, START, DATA, PARITY, GAP);
- the constant START_LEN=2;
- the parity function.
REQ-025 One sub-module, frame_shift_reg (load, shift-right, LSB output), is natural; all sequencing SHALL remain in serial_frame_tx.

Verification (DATA_W=8, IDLE_GAP=2)
REQ-026 Single frame: reset released, tx_data=0xA5 with tx_valid=1 for one cycle -> out = 1,1, 1,0,1,0,0,1,0,1, 0, 0,0; busy high for 13 cycles; one done pulse.
REQ-027 Back-to-back: 0x01 then 0xFF, tx_valid held high -> parity bits 1 then 0; second START begins exactly 14 cycles after the first.
REQ-028 Reset mid-frame: assert reset during the 4th DATA bit -> out=0 at the next edge, no done pulse. A subsequent 0x3C frame SHALL produce 1,1, 0,0,1,1,1,1,0,0, 0, 0,0.
REQ-029 Data stability: change tx_data to 0x00 and toggle tx_valid during the 0xA5 frame -> line sequence identical to REQ-026; tx_ready stays 0.
REQ-030 Idle hold: tx_valid=0 for 50 cycles after reset -> out=0, busy=0, done=0 and tx_ready=1 throughout.
